// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: latches one single-precision op, drives the shared FPU
// and returns result/flags/tag via a valid/ready response port.
// Ports:
//   clk, rstn (sync active-low), flush
//   req_*  : op request (valid/ready), op select, operands, tag
//   fpu_*  : operands/select/stall to FPU, done/result/ovf/unf from FPU
//   resp_* : response (valid/ready), result, tag, flags {tmo,ovf,unf}
//   busy   : sequencer not idle
module fpu_op_sequencer #(
   parameter int DIV_TIMEOUT = 64,
   parameter int TAG_W       = 5,
   parameter int CNT_W       = 7
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      fpu_a,
   output logic [31:0]      fpu_b,
   output logic [1:0]       fpu_sel,
   output logic             fpu_stall,
   input  logic             fpu_done,
   input  logic [31:0]      fpu_result,
   input  logic             fpu_ovf,
   input  logic             fpu_unf,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_result,
   output logic [TAG_W-1:0] resp_tag,
   output logic [2:0]       resp_flags,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE, EXEC, WAIT_DIV, RESP
   } state_t;

   state_t            r_state;
   logic [31:0]       r_a;
   logic [31:0]       r_b;
   logic [1:0]        r_sel;
   logic [TAG_W-1:0]  r_tag;
   logic [TAG_W-1:0]  r_rtag;
   logic [31:0]       r_res;
   logic [2:0]        r_flags;
   logic              r_valid;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_accept;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_tmo;

   assign w_accept  = (r_state == IDLE) && req_valid && !flush;
   assign w_cnt_nxt = r_cnt + 1'b1;
   // Counter after this cycle = cycles spent in EXEC+WAIT_DIV so far.
   assign w_tmo     = (w_cnt_nxt >= CNT_W'(DIV_TIMEOUT));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sel   <= 2'b00;
         r_tag   <= '0;
         r_rtag  <= '0;
         r_res   <= '0;
         r_flags <= '0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a     <= req_a;
                  r_b     <= req_b;
                  r_sel   <= req_op;
                  r_tag   <= req_tag;
                  r_cnt   <= '0;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               if (flush) begin
                  r_state <= IDLE;
                  r_sel   <= 2'b00;
                  r_valid <= 1'b0;
                  r_flags <= '0;
               end else begin
                  r_cnt <= w_cnt_nxt;
                  if (r_sel != 2'b11 || fpu_done) begin
                     r_res   <= fpu_result;
                     r_flags <= {1'b0, fpu_ovf, fpu_unf};
                     r_rtag  <= r_tag;
                     r_valid <= 1'b1;
                     r_state <= RESP;
                  end else begin
                     r_state <= WAIT_DIV;
                  end
               end
            end
            WAIT_DIV: begin
               if (flush) begin
                  r_state <= IDLE;
                  r_sel   <= 2'b00;
                  r_valid <= 1'b0;
                  r_flags <= '0;
               end else begin
                  r_cnt <= w_cnt_nxt;
                  // done has priority over a coinciding timeout
                  if (fpu_done) begin
                     r_res   <= fpu_result;
                     r_flags <= {1'b0, fpu_ovf, fpu_unf};
                     r_rtag  <= r_tag;
                     r_valid <= 1'b1;
                     r_state <= RESP;
                  end else if (w_tmo) begin
                     r_res   <= 32'h7FC0_0000;
                     r_flags <= 3'b100;
                     r_rtag  <= r_tag;
                     r_valid <= 1'b1;
                     r_state <= RESP;
                  end
               end
            end
            RESP: begin
               if (flush) begin
                  r_state <= IDLE;
                  r_sel   <= 2'b00;
                  r_valid <= 1'b0;
                  r_flags <= '0;
               end else if (resp_ready) begin
                  r_state <= IDLE;
                  r_sel   <= 2'b00;
                  r_valid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready   = (r_state == IDLE);
   assign busy        = (r_state != IDLE);
   assign fpu_stall   = (r_state == IDLE) || (r_state == RESP);
   assign fpu_a       = r_a;
   assign fpu_b       = r_b;
   assign fpu_sel     = r_sel;
   assign resp_valid  = r_valid;
   assign resp_result = r_res;
   assign resp_tag    = r_rtag;
   assign resp_flags  = r_flags;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: transaction-level model of fpu_op_sequencer timing
// and data, checked every cycle, plus directed literal expectations.
module tb_fpu_op_sequencer;

   localparam int T = 8;

   logic        clk;
   logic        rstn;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_tag;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic [1:0]  fpu_sel;
   logic        fpu_stall;
   logic        fpu_done;
   logic [31:0] fpu_result;
   logic        fpu_ovf;
   logic        fpu_unf;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic [4:0]  resp_tag;
   logic [2:0]  resp_flags;
   logic        busy;

   int checks = 0;
   int failures = 0;

   fpu_op_sequencer #(
      .DIV_TIMEOUT(T), .TAG_W(5), .CNT_W(7)
   ) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .req_tag(req_tag),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel),
      .fpu_stall(fpu_stall), .fpu_done(fpu_done),
      .fpu_result(fpu_result), .fpu_ovf(fpu_ovf),
      .fpu_unf(fpu_unf),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_tag(resp_tag),
      .resp_flags(resp_flags), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_ready"}, 32'(req_ready), 32'd1);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_valid"}, 32'(resp_valid), 32'd0);
      chk({nm, "_stall"}, 32'(fpu_stall), 32'd1);
      chk({nm, "_sel"}, 32'(fpu_sel), 32'd0);
   endtask

   task automatic chk_reset(input string nm);
      chk_idle(nm);
      chk({nm, "_a"}, fpu_a, 32'd0);
      chk({nm, "_b"}, fpu_b, 32'd0);
      chk({nm, "_res"}, resp_result, 32'd0);
      chk({nm, "_tag"}, 32'(resp_tag), 32'd0);
      chk({nm, "_flg"}, 32'(resp_flags), 32'd0);
   endtask

   // One transaction. Edge 0 is the accept edge; edge k is k cycles later.
   // done_at: edge at which fpu_done is high (div only); hold: cycles of
   // resp_ready low in RESP; flush_at/rst_at: edge to inject (0 = none).
   task automatic run_op(
      input  logic [1:0]  op,
      input  logic [31:0] a,
      input  logic [31:0] b,
      input  logic [4:0]  tag,
      input  int          done_at,
      input  int          hold,
      input  int          flush_at,
      input  int          rst_at,
      input  bit          fix,
      input  logic [31:0] fres,
      input  bit          fovf,
      input  bit          funf,
      output int          first_v,
      output logic [31:0] got_res,
      output logic [2:0]  got_flg
   );
      int K, H, E;
      bit tmo;
      logic [31:0] er, r;
      logic [2:0]  ef;
      bit o, u;
      tmo = (op == 2'b11) && (done_at > T);
      if (op != 2'b11) K = 1;
      else K = tmo ? T : done_at;
      H = K + hold + 1;
      E = H;
      if (flush_at > 0 && flush_at < E) E = flush_at;
      if (rst_at > 0 && rst_at <= E) E = rst_at;
      first_v = -1;
      got_res = '0;
      got_flg = '0;
      er = '0;
      ef = '0;
      chk_idle("pre");
      req_valid = 1'b1;
      req_op = op;
      req_a = a;
      req_b = b;
      req_tag = tag;
      fpu_done = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'($urandom);
      req_op = 2'($urandom);
      req_a = $urandom;
      req_b = $urandom;
      req_tag = 5'($urandom);
      chk("ex_a", fpu_a, a);
      chk("ex_b", fpu_b, b);
      chk("ex_sel", 32'(fpu_sel), 32'(op));
      chk("ex_stall", 32'(fpu_stall), 32'd0);
      chk("ex_ready", 32'(req_ready), 32'd0);
      chk("ex_valid", 32'(resp_valid), 32'd0);
      for (int k = 1; k <= E; k++) begin
         if (fix) begin
            r = fres; o = fovf; u = funf;
         end else begin
            r = $urandom; o = 1'($urandom); u = 1'($urandom);
         end
         fpu_result = r;
         fpu_ovf = o;
         fpu_unf = u;
         if (op == 2'b11 && k <= K) fpu_done = (k == done_at);
         else fpu_done = 1'($urandom);
         if (k <= K) resp_ready = 1'($urandom);
         else resp_ready = (k == H);
         flush = (k == flush_at);
         rstn = !(k == rst_at);
         if (k == K) begin
            if (tmo) begin
               er = 32'h7FC0_0000; ef = 3'b100;
            end else begin
               er = r; ef = {1'b0, o, u};
            end
         end
         @(posedge clk); #1;
         flush = 1'b0;
         rstn = 1'b1;
         if (resp_valid === 1'b1 && first_v < 0) begin
            first_v = k;
            got_res = resp_result;
            got_flg = resp_flags;
         end
         if (k < E) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_ready", 32'(req_ready), 32'd0);
            chk("run_stall", 32'(fpu_stall), (k < K) ? 32'd0 : 32'd1);
            chk("run_valid", 32'(resp_valid), (k >= K) ? 32'd1 : 32'd0);
            chk("run_a", fpu_a, a);
            chk("run_b", fpu_b, b);
            chk("run_sel", 32'(fpu_sel), 32'(op));
            if (k >= K) begin
               chk("resp_res", resp_result, er);
               chk("resp_tag", 32'(resp_tag), 32'(tag));
               chk("resp_flg", 32'(resp_flags), 32'(ef));
            end
         end else if (k == rst_at) begin
            chk_reset("rst_mid");
         end else begin
            chk_idle("end");
            if (k == flush_at) chk("flush_flg", 32'(resp_flags), 32'd0);
         end
      end
      req_valid = 1'b0;
      resp_ready = 1'b0;
      fpu_done = 1'b0;
   endtask

   int fv;
   logic [31:0] gr;
   logic [2:0]  gf;

   initial begin
      rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0;
      req_a = '0; req_b = '0; req_tag = '0; fpu_done = 1'b0;
      fpu_result = '0; fpu_ovf = 1'b0; fpu_unf = 1'b0;
      resp_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_reset("reset");
      rstn = 1'b1;
      @(posedge clk); #1;
      chk_reset("post_rst");

      // add 1.0 + 2.0 = 3.0
      run_op(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'h11, 0, 0, 0, 0,
             1, 32'h4040_0000, 0, 0, fv, gr, gf);
      chk("add_lat", 32'(fv), 32'd1);
      chk("add_res", gr, 32'h4040_0000);
      chk("add_flg", 32'(gf), 32'd0);

      // div 6.0 / 2.0, done 5 cycles after accept
      run_op(2'b11, 32'h40C0_0000, 32'h4000_0000, 5'h03, 5, 0, 0, 0,
             1, 32'h4040_0000, 0, 0, fv, gr, gf);
      chk("div_lat", 32'(fv), 32'd5);
      chk("div_res", gr, 32'h4040_0000);

      // div timeout
      run_op(2'b11, 32'h3F80_0000, 32'h0, 5'h07, 100, 1, 0, 0,
             1, 32'h1234_5678, 0, 0, fv, gr, gf);
      chk("tmo_lat", 32'(fv), 32'd8);
      chk("tmo_res", gr, 32'h7FC0_0000);
      chk("tmo_flg", 32'(gf), 32'd4);

      // done coincides with timeout: normal result
      run_op(2'b11, 32'h4000_0000, 32'h4000_0000, 5'h08, 8, 0, 0, 0,
             1, 32'h3F80_0000, 0, 0, fv, gr, gf);
      chk("coin_lat", 32'(fv), 32'd8);
      chk("coin_res", gr, 32'h3F80_0000);
      chk("coin_flg", 32'(gf), 32'd0);

      // mul overflow with resp_ready held low 5 cycles
      run_op(2'b10, 32'h7F00_0000, 32'h7F00_0000, 5'h1F, 0, 5, 0, 0,
             1, 32'h7F80_0000, 1, 0, fv, gr, gf);
      chk("mul_res", gr, 32'h7F80_0000);
      chk("mul_flg", 32'(gf), 32'd2);
      @(posedge clk); #1;
      chk_idle("mul_single");

      // flush in WAIT_DIV
      run_op(2'b11, 32'h1, 32'h2, 5'h01, 20, 0, 3, 0,
             0, 32'h0, 0, 0, fv, gr, gf);
      chk("flw_nov", 32'(fv), 32'hFFFF_FFFF);

      // flush in RESP, and flush beating resp_ready
      run_op(2'b01, 32'h3, 32'h4, 5'h02, 0, 3, 3, 0,
             0, 32'h0, 0, 0, fv, gr, gf);
      run_op(2'b00, 32'h5, 32'h6, 5'h04, 0, 2, 4, 0,
             0, 32'h0, 0, 0, fv, gr, gf);

      // reset mid-divide
      run_op(2'b11, 32'h7, 32'h8, 5'h09, 20, 0, 0, 4,
             0, 32'h0, 0, 0, fv, gr, gf);

      // flush blocks accept
      req_valid = 1'b1; req_op = 2'b10; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      chk_idle("flush_blk");

      // add after disturbances
      run_op(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'h15, 0, 0, 0, 0,
             1, 32'h4040_0000, 0, 0, fv, gr, gf);
      chk("add2_res", gr, 32'h4040_0000);
      chk("add2_lat", 32'(fv), 32'd1);

      for (int i = 0; i < 200; i++) begin
         int fa, ra;
         fa = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : 0;
         ra = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 10) : 0;
         run_op(2'($urandom), $urandom, $urandom, 5'($urandom),
                $urandom_range(1, 12), $urandom_range(0, 3), fa, ra,
                0, 32'h0, 0, 0, fv, gr, gf);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            chk_idle("gap");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
